wm8731_cfg_seq: RTL and testbench

- Power-up configuration sequencer for the WM8731 audio codec.
- Walks a fixed 11-entry register table and builds each 24-bit I2C write packet: device address byte, 7-bit register address, 9-bit data.
- Hands each packet to the downstream I2C master through a pulse/done handshake, with retry, timeout and post-reset settle delay.
- Sits between system control (start/status) and the I2C master driving the codec's SDAT/SCLK.

---
 rtl/wm8731_cfg_seq_if.sv | 24 ++
 rtl/wm8731_cfg_seq.sv | 153 +++++++++++++++
 tb/tb_wm8731_cfg_seq.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/wm8731_cfg_seq_if.sv
// Handshake bundle between the WM8731 config sequencer, system control and the I2C master.
// master = sequencer side, slave = the environment (control logic plus I2C master).
interface wm8731_cfg_seq_if;
    logic        start;
    logic        i2c_busy;
    logic        i2c_done;
    logic        i2c_ack_err;
    logic [23:0] i2c_packet;
    logic        wr_i2c;
    logic        busy;
    logic        done;
    logic        error;
    logic [3:0]  reg_index;

    modport master (
        input  start, i2c_busy, i2c_done, i2c_ack_err,
        output i2c_packet, wr_i2c, busy, done, error, reg_index
    );

    modport slave (
        output start, i2c_busy, i2c_done, i2c_ack_err,
        input  i2c_packet, wr_i2c, busy, done, error, reg_index
    );
endinterface

// File: rtl/wm8731_cfg_seq.sv
// WM8731 power-up sequencer: writes an 11-entry register table over I2C with retry,
// timeout and a settle delay after the codec reset write. Per entry 3+D cycles, wr_i2c held off by i2c_busy.
module wm8731_cfg_seq #(
    parameter logic [7:0] DEV_ADDR       = 8'h34,
    parameter int         MAX_RETRY      = 3,
    parameter int         SETTLE_CYCLES  = 1000,
    parameter int         TIMEOUT_CYCLES = 65535
) (
    input  logic             clk,
    input  logic             rst,
    wm8731_cfg_seq_if.master bus
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int SW = $clog2(SETTLE_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, LOAD, SEND, WAIT, SETTLE, NEXT, DONE, FAIL} state_t;

    state_t          state_q, state_d;
    logic [23:0]     pkt_q, pkt_d;
    logic            wr_q, wr_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic [3:0]      idx_q, idx_d;
    logic [2:0]      retry_q, retry_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic [SW-1:0]   settle_q, settle_d;

    // {reg_addr[6:0], reg_data[8:0]}; entry 0 is the R15 reset write.
    function automatic logic [15:0] table_entry(input logic [3:0] idx);
        case (idx)
            4'd0:    table_entry = {7'h0F, 9'h000};
            4'd1:    table_entry = {7'h06, 9'h000};
            4'd2:    table_entry = {7'h00, 9'h017};
            4'd3:    table_entry = {7'h01, 9'h017};
            4'd4:    table_entry = {7'h02, 9'h079};
            4'd5:    table_entry = {7'h03, 9'h079};
            4'd6:    table_entry = {7'h04, 9'h012};
            4'd7:    table_entry = {7'h05, 9'h000};
            4'd8:    table_entry = {7'h07, 9'h00A};
            4'd9:    table_entry = {7'h08, 9'h000};
            4'd10:   table_entry = {7'h09, 9'h001};
            default: table_entry = 16'h0000;
        endcase
    endfunction

    always_comb begin
        state_d  = state_q;
        pkt_d    = pkt_q;
        wr_d     = 1'b0;
        busy_d   = busy_q;
        done_d   = done_q;
        err_d    = err_q;
        idx_d    = idx_q;
        retry_d  = retry_q;
        tmo_d    = tmo_q;
        settle_d = settle_q;
        case (state_q)
            IDLE, DONE, FAIL: begin
                if (state_q == DONE) begin
                    done_d = 1'b1;
                    busy_d = 1'b0;
                end
                if (state_q == FAIL) begin
                    err_d  = 1'b1;
                    busy_d = 1'b0;
                end
                // busy_q is still high in the first DONE/FAIL cycle, so start is ignored there.
                if (bus.start && !busy_q) begin
                    state_d = LOAD;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    idx_d   = 4'd0;
                    retry_d = 3'd0;
                end
            end
            LOAD: begin
                pkt_d   = {DEV_ADDR, table_entry(idx_q)};
                state_d = SEND;
            end
            SEND: begin
                if (!bus.i2c_busy) begin
                    wr_d    = 1'b1;
                    tmo_d   = '0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (bus.i2c_done && !bus.i2c_ack_err) begin
                    settle_d = '0;
                    state_d  = (idx_q == 4'd0) ? SETTLE : NEXT;
                end else if (bus.i2c_done || tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    if (retry_q < 3'(MAX_RETRY)) begin
                        retry_d = retry_q + 3'd1;
                        state_d = SEND;
                    end else begin
                        state_d = FAIL;
                    end
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            SETTLE: begin
                if (settle_q == SW'(SETTLE_CYCLES - 1)) state_d = NEXT;
                else settle_d = settle_q + SW'(1);
            end
            NEXT: begin
                if (idx_q == 4'd10) begin
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + 4'd1;
                    retry_d = 3'd0;
                    state_d = LOAD;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            pkt_q    <= '0;
            wr_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            idx_q    <= '0;
            retry_q  <= '0;
            tmo_q    <= '0;
            settle_q <= '0;
        end else begin
            state_q  <= state_d;
            pkt_q    <= pkt_d;
            wr_q     <= wr_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
            idx_q    <= idx_d;
            retry_q  <= retry_d;
            tmo_q    <= tmo_d;
            settle_q <= settle_d;
        end
    end

    assign bus.i2c_packet = pkt_q;
    assign bus.wr_i2c     = wr_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.error      = err_q;
    assign bus.reg_index  = idx_q;
endmodule

// File: tb/tb_wm8731_cfg_seq.sv
// Bench for wm8731_cfg_seq: an I2C-master responder with a table-driven expectation model,
// plus directed scenarios (clean run, NACK retry, retry exhaustion, timeout, stall, reset).
`timescale 1ns/1ps
module tb_wm8731_cfg_seq;
    localparam int MAXR   = 3;
    localparam int SETTLE = 50;
    localparam int TMO    = 100;
    localparam int D      = 20;
    localparam int N_NOM  = 11 * (3 + D) + SETTLE + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wm8731_cfg_seq_if bus();

    wm8731_cfg_seq #(
        .DEV_ADDR(8'h34), .MAX_RETRY(MAXR), .SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Codec register table as plain numbers; packet = dev<<16 | reg<<9 | data.
    int regs [11] = '{15, 6, 0, 1, 2, 3, 4, 5, 7, 8, 9};
    int vals [11] = '{'h000, 'h000, 'h017, 'h017, 'h079, 'h079, 'h012, 'h000, 'h00A, 'h000, 'h001};

    function automatic logic [23:0] exp_pkt(input int i);
        return 24'((32'h34 << 16) | (regs[i] << 9) | vals[i]);
    endfunction

    int   cyc = 0;
    logic busy_at_edge = 1'b0;
    always @(posedge clk) begin
        cyc          <= cyc + 1;
        busy_at_edge <= bus.i2c_busy;
    end

    // Model state: which entry / attempt the next write must be, and the expected gap to it.
    int   m_idx, m_att, m_gap, m_last_wr, m_over, cd, wr_total;
    int   nack_entry = -1, nack_limit = 0, silent_entry = -1;
    logic pend_nack = 1'b0, prev_wr = 1'b0;
    logic [23:0] pkt_log [32];

    task automatic model_reset();
        m_idx = 0; m_att = 0; m_gap = 0; m_over = 0; wr_total = 0; cd = 0;
    endtask

    always @(negedge clk) begin
        if (rst) begin
            cd = 0;
            bus.i2c_done = 1'b0;
            bus.i2c_ack_err = 1'b0;
        end else begin
            bus.i2c_done = 1'b0;
            bus.i2c_ack_err = 1'b0;
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    bus.i2c_done = 1'b1;
                    bus.i2c_ack_err = pend_nack;
                    if (pend_nack) begin
                        m_att++;
                        if (m_att > MAXR) m_over = 1;
                    end else begin
                        m_idx++;
                        m_att = 0;
                        if (m_idx == 11) m_over = 1;
                    end
                end
            end
            if (bus.wr_i2c) begin
                if (wr_total < 32) pkt_log[wr_total] = bus.i2c_packet;
                wr_total++;
                chk("wr_one_cycle", prev_wr, 0);
                chk("wr_expected", m_over, 0);
                chk("busy_during_wr", bus.busy, 1);
                chk("i2c_busy_low_at_wr", busy_at_edge, 0);
                if (m_gap != 0) chk("retry_gap", cyc - m_last_wr, m_gap);
                m_last_wr = cyc;
                if (m_over == 0) begin
                    chk("packet", bus.i2c_packet, exp_pkt(m_idx));
                    chk("reg_index_at_wr", bus.reg_index, m_idx);
                    if (m_idx == silent_entry && m_att == 0) begin
                        m_att++;
                        m_gap = TMO + 1;
                    end else begin
                        pend_nack = (m_idx == nack_entry) && (m_att < nack_limit);
                        m_gap = pend_nack ? D + 1 : 0;
                        cd = D - 1;
                    end
                end
            end
            prev_wr = bus.wr_i2c;
        end
    end

    task automatic do_start(output int t0);
        @(negedge clk);
        model_reset();
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        t0 = cyc;
        chk("start_sets_busy", bus.busy, 1);
        chk("start_clears_done", bus.done, 0);
        chk("start_clears_error", bus.error, 0);
    endtask

    task automatic wait_end(input int t0, output int lat);
        int k;
        for (k = 0; k < 5000; k++) begin
            @(negedge clk);
            if (bus.done || bus.error) break;
        end
        if (k == 5000) chk("end_timeout", 0, 1);
        lat = cyc - t0;
    endtask

    task automatic wait_wr_idx(input int idx);
        int k;
        for (k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (bus.wr_i2c && bus.reg_index == 4'(idx)) break;
        end
        if (k == 3000) chk("wait_wr_timeout", 0, 1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_packet"}, bus.i2c_packet, 0);
        chk({tag, "_wr"}, bus.wr_i2c, 0);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_done"}, bus.done, 0);
        chk({tag, "_error"}, bus.error, 0);
        chk({tag, "_reg_index"}, bus.reg_index, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, lat;
        bus.start = 1'b0;
        bus.i2c_busy = 1'b0;
        model_reset();
        #12;
        chk_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("idle_no_wr", wr_total, 0);

        // Clean run with a stray start mid-sequence.
        do_start(t0);
        repeat (100) @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_end(t0, lat);
        chk("clean_latency", lat, N_NOM);
        chk("clean_done", bus.done, 1);
        chk("clean_busy", bus.busy, 0);
        chk("clean_error", bus.error, 0);
        chk("clean_reg_index", bus.reg_index, 10);
        chk("clean_wr_count", wr_total, 11);
        chk("clean_pkt0", pkt_log[0], 24'h341E00);
        chk("clean_pkt1", pkt_log[1], 24'h340C00);
        chk("clean_pkt4", pkt_log[4], 24'h340479);
        chk("clean_pkt8", pkt_log[8], 24'h340E0A);
        chk("clean_pkt10", pkt_log[10], 24'h341201);

        // Restart after done; one NACK on entry 4.
        nack_entry = 4; nack_limit = 1;
        do_start(t0);
        wait_end(t0, lat);
        chk("nack1_latency", lat, N_NOM + D + 1);
        chk("nack1_done", bus.done, 1);
        chk("nack1_wr_count", wr_total, 12);
        chk("nack1_pkt4", pkt_log[4], 24'h340479);
        chk("nack1_pkt5", pkt_log[5], 24'h340479);
        chk("nack1_pkt0", pkt_log[0], 24'h341E00);

        // Entry 2 NACKs on every attempt: 1 + MAX_RETRY writes, then FAIL.
        nack_entry = 2; nack_limit = 99;
        do_start(t0);
        wait_end(t0, lat);
        chk("fail_latency", lat, 2 * (3 + D) + SETTLE + 2 + 4 * D + 3 + 1);
        chk("fail_error", bus.error, 1);
        chk("fail_done", bus.done, 0);
        chk("fail_busy", bus.busy, 0);
        chk("fail_reg_index", bus.reg_index, 2);
        chk("fail_wr_count", wr_total, 6);
        chk("fail_pkt5", pkt_log[5], 24'h340017);
        repeat (200) @(negedge clk);
        chk("fail_no_more_wr", wr_total, 6);
        chk("fail_error_sticky", bus.error, 1);

        // Silent first attempt on entry 3 (timeout), then i2c_busy stall ahead of entry 8.
        nack_entry = -1; nack_limit = 0; silent_entry = 3;
        do_start(t0);
        wait_wr_idx(7);
        bus.i2c_busy = 1'b1;
        repeat (50) @(negedge clk);
        chk("stall_no_wr", wr_total, 9);
        chk("stall_pkt_stable", bus.i2c_packet, 24'h340E0A);
        bus.i2c_busy = 1'b0;
        @(negedge clk);
        chk("stall_wr_after_release", bus.wr_i2c, 1);
        wait_end(t0, lat);
        chk("tmo_latency", lat, N_NOM + TMO + 1 + 28);
        chk("tmo_done", bus.done, 1);
        chk("tmo_wr_count", wr_total, 12);
        chk("tmo_pkt4", pkt_log[4], 24'h340017 + 24'h200);
        silent_entry = -1;

        // Reset while waiting on entry 6.
        do_start(t0);
        wait_wr_idx(6);
        repeat (5) @(negedge clk);
        #1 rst = 1'b1;
        #1 chk_all_zero("midreset");
        @(negedge clk);
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (100) @(negedge clk);
        chk("post_reset_no_wr", wr_total, 0);
        chk("post_reset_busy", bus.busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
